sobel_window_gen: RTL and testbench

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_window_gen_pkg.sv | 18 +
 rtl/sobel_window_gen_if.sv | 31 +++
 rtl/sobel_window_gen_line_buf.sv | 29 ++
 rtl/sobel_window_gen.sv | 137 +++++++++++++
 tb/tb_sobel_window_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_window_gen_pkg.sv
// sobel_pkg: shared defaults for the Sobel 3x3 window generator.
//   PIX_W_DEF / IMG_W_DEF / IMG_H_DEF : default pixel width and frame size.
//   COL_W_DEF / ROW_W_DEF             : counter widths derived from the defaults.
//   cnt_w()                           : counter width for an n-entry range (min 1).
package sobel_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(IMG_W_DEF);
    localparam int ROW_W_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, 3x3 window stream out.
//   pixel_in/pixel_valid             : raster-order pixel source.
//   win_out                          : 3x3 window, element (r,c) at [(3*r+c)*PIX_W +: PIX_W].
//   win_valid/win_first/win_last     : window strobe and frame markers.
//   win_count                        : emitted-window count (only with SOBEL_WIN_COUNT_EN).
// master = pixel source / window sink, slave = window generator.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic [PIX_W-1:0]   pixel_in;
    logic               pixel_valid;
    logic [9*PIX_W-1:0] win_out;
    logic               win_valid;
    logic               win_first;
    logic               win_last;
`ifdef SOBEL_WIN_COUNT_EN
    logic [15:0]        win_count;

    modport master (output pixel_in, pixel_valid,
                    input  win_out, win_valid, win_first, win_last, win_count);
    modport slave  (input  pixel_in, pixel_valid,
                    output win_out, win_valid, win_first, win_last, win_count);
`else
    modport master (output pixel_in, pixel_valid,
                    input  win_out, win_valid, win_first, win_last);
    modport slave  (input  pixel_in, pixel_valid,
                    output win_out, win_valid, win_first, win_last);
`endif
endinterface

// File: rtl/sobel_window_gen_line_buf.sv
// sobel_line_buf: one DEPTH x WIDTH line buffer.
//   addr  : shared read/write address.
//   rdata : combinational read of the current contents at addr, so a write
//           on the same edge returns the old value (read-before-write).
//   we/wdata : synchronous write on the rising edge.
// Contents are not reset.
module sobel_line_buf #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: builds 3x3 pixel windows from a raster pixel stream.
//   clk  : single clock, rising edge.
//   rst  : asynchronous active-low reset.
//   bus  : sobel_window_gen_if.slave (pixel in, window out, frame markers).
// Only interior windows are emitted: the window completed by pixel (row,col)
// with row>=2 and col>=2, one cycle after that pixel is accepted.
// Optional macro SOBEL_WIN_COUNT_EN adds bus.win_count (saturating count of
// windows emitted in the current frame, loaded with 1 on win_first).
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic             win_valid_q, win_valid_d;
    logic             win_first_q, win_first_d;
    logic             win_last_q,  win_last_d;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    // lb1 holds the previous row; lb2 is fed from lb1's outgoing value so it
    // holds the row before that.
    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb1 (
        .clk   (clk),
        .we    (bus.pixel_valid),
        .addr  (col_q),
        .wdata (bus.pixel_in),
        .rdata (lb1_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb2 (
        .clk   (clk),
        .we    (bus.pixel_valid),
        .addr  (col_q),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_first_d = 1'b0;
        win_last_d  = 1'b0;
        if (bus.pixel_valid) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = bus.pixel_in;
            // Interior gating also hides columns that straddle a line wrap
            // and line-buffer data left over from a previous frame.
            win_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            win_first_d = (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
            win_last_d  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '{default: '0};
            win_valid_q <= 1'b0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            win_first_q <= win_first_d;
            win_last_q  <= win_last_d;
        end
    end

    always_comb begin
        bus.win_out = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                bus.win_out[(3*r+c)*PIX_W +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_first = win_first_q;
    assign bus.win_last  = win_last_q;

`ifdef SOBEL_WIN_COUNT_EN
    logic [15:0] win_count_q, win_count_d;

    // Counts on the emitting edge so the value shown with a window includes it.
    always_comb begin
        win_count_d = win_count_q;
        if (win_valid_d) begin
            if (win_first_d) begin
                win_count_d = 16'd1;
            end else if (win_count_q != 16'hFFFF) begin
                win_count_d = win_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_count_q <= '0;
        end else begin
            win_count_q <= win_count_d;
        end
    end

    assign bus.win_count = win_count_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed bench for sobel_window_gen on a reduced
// 10x7 frame (non-power-of-two sizes exercise the counter wraps).
// Expected windows come from the bench's own pixel-coordinate model.
// Build with +define+SOBEL_WIN_COUNT_EN to also check win_count.
module tb_sobel_window_gen;

    localparam int IMG_W = 10;
    localparam int IMG_H = 7;
    localparam int PIX_W = 8;
    localparam int NPIX  = IMG_W * IMG_H;                // 70
    localparam int WINS  = (IMG_H - 2) * (IMG_W - 2);    // 40
    localparam int FIRST_IDX = 2 * IMG_W + 2;            // 22: pixel (2,2)

    logic clk = 1'b0;
    logic rst = 1'b0;

    sobel_window_gen_if #(.PIX_W(PIX_W)) bus ();

    sobel_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Bench model: coordinates of the next pixel to be accepted and the
    // outputs expected after the most recent edge.
    int                 mrow = 0;
    int                 mcol = 0;
    logic               exp_valid, exp_first, exp_last;
    logic [9*PIX_W-1:0] exp_win = '0;

    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        logic [7:0] v;
        v = 8'(r + c);
        return (kind != 0) ? ~v : v;
    endfunction

    // Drive one cycle of stimulus and advance the model; no checking here.
    task automatic cycle(input logic v, input int kind);
        bus.pixel_valid = v;
        bus.pixel_in    = v ? pix(kind, mrow, mcol) : 8'($urandom);
        @(posedge clk);
        exp_valid = v && (mrow >= 2) && (mcol >= 2);
        exp_first = exp_valid && (mrow == 2) && (mcol == 2);
        exp_last  = v && (mrow == IMG_H - 1) && (mcol == IMG_W - 1);
        if (v) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_win[(3*r+c)*PIX_W +: PIX_W] = pix(kind, mrow - 2 + r, mcol - 2 + c);
            if (mcol == IMG_W - 1) begin
                mcol = 0;
                mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
            end else begin
                mcol = mcol + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pixel_valid = i[0];
            bus.pixel_in    = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (bus.win_valid !== 1'b0 || bus.win_first !== 1'b0 || bus.win_last !== 1'b0) begin
                failures++;
                $display("FAIL reset_flags cyc=%0d got v/f/l=%b%b%b exp=000",
                         i, bus.win_valid, bus.win_first, bus.win_last);
            end
            checks++;
            if (bus.win_out !== '0) begin
                failures++;
                $display("FAIL reset_win cyc=%0d got=%h exp=0", i, bus.win_out);
            end
        end
        bus.pixel_valid = 1'b0;
        rst  = 1'b1;
        mrow = 0;
        mcol = 0;
    endtask

    // One ramp frame at continuous valid, or with valid alternating 1/0.
    task automatic test_ramp(input string tag, input logic alternate);
        int npulse   = 0;
        int accepted = 0;
        int first_at = -1;
        logic v;
        for (int i = 0; accepted < NPIX; i++) begin
            v = alternate ? ~i[0] : 1'b1;
            cycle(v, 0);
            if (v) accepted++;
            checks++;
            if (bus.win_valid !== exp_valid) begin
                failures++;
                $display("FAIL %s_valid acc=%0d got=%b exp=%b", tag, accepted, bus.win_valid, exp_valid);
            end
            checks++;
            if (bus.win_first !== exp_first || bus.win_last !== exp_last) begin
                failures++;
                $display("FAIL %s_marks acc=%0d got f/l=%b%b exp=%b%b", tag, accepted,
                         bus.win_first, bus.win_last, exp_first, exp_last);
            end
            if (bus.win_valid === 1'b1) begin
                npulse++;
                if (first_at < 0) first_at = accepted;
            end
            if (exp_valid) begin
                checks++;
                if (bus.win_out !== exp_win) begin
                    failures++;
                    $display("FAIL %s_win acc=%0d got=%h exp=%h", tag, accepted, bus.win_out, exp_win);
                end
            end
            if (exp_first) begin
                checks++;
                if (bus.win_out[0 +: 8] !== 8'd0 || bus.win_out[16 +: 8] !== 8'd2 ||
                    bus.win_out[32 +: 8] !== 8'd2 || bus.win_out[64 +: 8] !== 8'd4) begin
                    failures++;
                    $display("FAIL %s_first_elems got 00/02/11/22=%0d/%0d/%0d/%0d exp=0/2/2/4", tag,
                             bus.win_out[0 +: 8], bus.win_out[16 +: 8], bus.win_out[32 +: 8], bus.win_out[64 +: 8]);
                end
            end
            if (exp_last) begin
                checks++;
                if (bus.win_out[64 +: 8] !== 8'd15) begin
                    failures++;
                    $display("FAIL %s_last_elem got=%0d exp=15", tag, bus.win_out[64 +: 8]);
                end
            end
        end
        checks++;
        if (npulse != WINS) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", tag, npulse, WINS);
        end
        checks++;
        if (first_at != FIRST_IDX + 1) begin
            failures++;
            $display("FAIL %s_first_at got=%0d exp=%0d", tag, first_at, FIRST_IDX + 1);
        end
        cycle(1'b0, 0);
    endtask

    // Async reset mid-frame right after a window-emitting pixel, then a fresh frame.
    task automatic test_reset_mid;
        for (int i = 0; i < 3 * IMG_W + 3; i++) cycle(1'b1, 0);
        checks++;
        if (bus.win_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre_valid got=%b exp=1", bus.win_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.win_out !== '0) begin
            failures++;
            $display("FAIL rstmid_async got valid=%b win=%h exp=0/0", bus.win_valid, bus.win_out);
        end
        for (int i = 0; i < 3; i++) begin
            bus.pixel_valid = i[0];
            @(posedge clk);
        end
        #1;
        bus.pixel_valid = 1'b0;
        rst  = 1'b1;
        mrow = 0;
        mcol = 0;
        test_ramp("rstmid", 1'b0);
    endtask

    // Ramp frame followed immediately by an inverted-ramp frame.
    task automatic test_back_to_back;
        int npulse [2] = '{0, 0};
        int f;
        for (int i = 0; i < 2 * NPIX; i++) begin
            f = (i < NPIX) ? 0 : 1;
            cycle(1'b1, f);
            checks++;
            if (bus.win_valid !== exp_valid || bus.win_first !== exp_first || bus.win_last !== exp_last) begin
                failures++;
                $display("FAIL b2b_flags pix=%0d got v/f/l=%b%b%b exp=%b%b%b", i,
                         bus.win_valid, bus.win_first, bus.win_last, exp_valid, exp_first, exp_last);
            end
            if (bus.win_valid === 1'b1) npulse[f]++;
            if (exp_valid) begin
                checks++;
                if (bus.win_out !== exp_win) begin
                    failures++;
                    $display("FAIL b2b_win pix=%0d got=%h exp=%h", i, bus.win_out, exp_win);
                end
            end
            if (exp_first && f == 1) begin
                checks++;
                if (bus.win_out[0 +: 8] !== 8'hFF || bus.win_out[64 +: 8] !== 8'hFB) begin
                    failures++;
                    $display("FAIL b2b_first2 got 00/22=%h/%h exp=ff/fb",
                             bus.win_out[0 +: 8], bus.win_out[64 +: 8]);
                end
            end
`ifdef SOBEL_WIN_COUNT_EN
            if (exp_last) begin
                checks++;
                if (bus.win_count !== 16'(WINS)) begin
                    failures++;
                    $display("FAIL b2b_win_count frame=%0d got=%0d exp=%0d", f, bus.win_count, WINS);
                end
            end
`endif
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (npulse[k] != WINS) begin
                failures++;
                $display("FAIL b2b_count frame=%0d got=%0d exp=%0d", k, npulse[k], WINS);
            end
        end
        cycle(1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_ramp("ramp", 1'b0);
        test_ramp("stall", 1'b1);
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
